regfile_writeback: RTL and testbench
====================================

// Module: regfile_writeback
// PURPOSE
//  Write-side initiator for the 8x8 register file. Accepts ALU/load results over valid/ready.
//  Buffers them in a small in-order FIFO and drains one entry per cycle onto the register
//  file's synchronous write port (write_reg/write_data/write_en).
//  Provides bypass lookups for both read ports, so operand reads see results that are
//  still pending and not yet written.
// PARAMETERS
//  DATA_W  8  result / register data width
//  ADDR_W  3  register index width (2**ADDR_W registers)
//  DEPTH   4  FIFO entries, power of two, >=2
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous, active-high reset
//  in_valid   in   1       producer has a result
//  in_ready   out  1       FIFO can accept (count < DEPTH)
//  in_reg     in   ADDR_W  destination register of result
//  in_data    in   DATA_W  result value
//  hold       in   1       inhibit draining this cycle
//  wr_en      out  1       to register file write_en (registered)
//  wr_reg     out  ADDR_W  to register file write_reg (registered)
//  wr_data    out  DATA_W  to register file write_data (registered)
//  q_reg1     in   ADDR_W  bypass query, mirrors read_reg1
//  q_reg2     in   ADDR_W  bypass query, mirrors read_reg2
//  byp_hit1   out  1       pending write to q_reg1 exists
//  byp_data1  out  DATA_W  youngest pending value for q_reg1
//  byp_hit2   out  1       pending write to q_reg2 exists
//  byp_data2  out  DATA_W  youngest pending value for q_reg2
//  count      out  ADDR_W+1 entries in FIFO (excludes output stage)
//  busy       out  1       count!=0 or wr_en
// BEHAVIOUR
//  Reset (async, any time): count=0, rd/wr ptrs=0, wr_en=0, wr_reg=0, wr_data=0.
//   Pending entries are discarded, never written. After reset: in_ready=1, byp_hit*=0, busy=0.
//  Push: in_valid & in_ready at edge -> in_reg/in_data stored at wr_ptr; wr_ptr wraps mod DEPTH.
//  in_ready = (count<DEPTH), combinational from count only. When full, no push in the same
//   cycle as a pop. The producer must hold in_valid/in_reg/in_data stable until accepted.
//  Pop: at edge, if count!=0 & !hold -> head copied to wr_reg/wr_data, wr_en<=1; rd_ptr wraps.
//   Otherwise wr_en<=0; wr_reg/wr_data keep their values.
//  Simultaneous push+pop (not full): count unchanged. Push into empty FIFO cannot pop in the same edge.
//  Latency: accepted at edge E0 -> wr_en high after E1 -> register file updated at E2 (min 2 cycles).
//  Ordering: strict FIFO. Two results to the same register commit in arrival order; the last one wins.
//  Bypass (combinational): search FIFO entries plus the output stage (when wr_en=1) for a match.
//   Priority is youngest FIFO entry, then older entries, then the output stage.
//   No match -> hit=0, data=0. Accepting an entry makes it visible to bypass in the next cycle.
//  hold high: FIFO keeps filling up to DEPTH; wr_en drops to 0 the cycle after hold rises.
//  count never exceeds DEPTH and never underflows. Pointers use ADDR bits of log2(DEPTH).
// TESTING
//  1. Reset, then push r3=0x5A in one cycle -> wr_en=1,wr_reg=3,wr_data=0x5A exactly 2 edges later, one cycle.
//  2. hold=1, push r1..r4=0x11..0x44 -> count=4, in_ready=0. A 5th push is refused.
//     Release hold -> 4 consecutive writes in order, then busy=0.
//  3. Push r2=0x10 then r2=0x20, query q_reg1=2 -> byp_hit1=1, byp_data1=0x20. After drain, hit=0 and the file holds 0x20.
//  4. Keep the FIFO at count=2 with a push and a pop each cycle for 8 cycles -> count stays 2.
//     Pointers wrap past DEPTH-1 and no entry is lost or duplicated.
//  5. Assert rst asynchronously with 3 entries pending -> wr_en=0 and count=0 immediately. No pending entry is ever written.
//  6. Query q_reg2=7 with no pending r7 -> byp_hit2=0, byp_data2=0x00.

Source files
------------

// File: rtl/regfile_writeback.sv
// Write-side initiator for the 8x8 register file: buffers results in an in-order FIFO,
// drains one per cycle onto the file's write port and offers bypass lookups for two read ports.
module regfile_writeback #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ADDR_W-1:0] in_reg_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              hold_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_reg_o,
  output logic [DATA_W-1:0] wr_data_o,
  input  logic [ADDR_W-1:0] q_reg1_i,
  input  logic [ADDR_W-1:0] q_reg2_i,
  output logic              byp_hit1_o,
  output logic [DATA_W-1:0] byp_data1_o,
  output logic              byp_hit2_o,
  output logic [DATA_W-1:0] byp_data2_o,
  output logic [ADDR_W:0]   count_o,
  output logic              busy_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] reg_mem_q  [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic push;
  logic pop;

  // in_ready depends on count alone, so a full FIFO never accepts alongside a pop.
  assign in_ready_o = (count_q < DEPTH_CNT);
  assign push       = in_valid_i & in_ready_o;
  assign pop        = (count_q != '0) & ~hold_i;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    wr_en_d   = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      wr_en_d   = 1'b1;
      wr_reg_d  = reg_mem_q[rd_ptr_q];
      wr_data_d = data_mem_q[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Storage slots carry no reset: liveness comes from the pointers and count.
  logic [DEPTH-1:0] live;
  logic [DEPTH-1:0] match1;
  logic [DEPTH-1:0] match2;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [PTR_W-1:0] age;

    always_ff @(posedge clk_i) begin
      if (push && (wr_ptr_q == PTR_W'(gi))) begin
        reg_mem_q[gi]  <= in_reg_i;
        data_mem_q[gi] <= in_data_i;
      end
    end

    assign age        = PTR_W'(gi) - rd_ptr_q;
    assign live[gi]   = ((ADDR_W+1)'(age) < count_q);
    assign match1[gi] = live[gi] && (reg_mem_q[gi] == q_reg1_i);
    assign match2[gi] = live[gi] && (reg_mem_q[gi] == q_reg2_i);
  end

  // Scan oldest to youngest so the youngest matching entry overrides; output stage is lowest.
  always_comb begin
    byp_hit1_o  = wr_en_q && (wr_reg_q == q_reg1_i);
    byp_data1_o = byp_hit1_o ? wr_data_q : '0;
    byp_hit2_o  = wr_en_q && (wr_reg_q == q_reg2_i);
    byp_data2_o = byp_hit2_o ? wr_data_q : '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match1[rd_ptr_q + PTR_W'(k)]) begin
        byp_hit1_o  = 1'b1;
        byp_data1_o = data_mem_q[rd_ptr_q + PTR_W'(k)];
      end
      if (match2[rd_ptr_q + PTR_W'(k)]) begin
        byp_hit2_o  = 1'b1;
        byp_data2_o = data_mem_q[rd_ptr_q + PTR_W'(k)];
      end
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_reg_o  = wr_reg_q;
  assign wr_data_o = wr_data_q;
  assign count_o   = count_q;
  assign busy_o    = (count_q != '0) | wr_en_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: a scoreboard of expected register-file writes
// plus per-scenario tasks checking latency, hold, bypass, steady flow and async reset.
module tb_regfile_writeback;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [2:0] in_reg_i;
  logic [7:0] in_data_i;
  logic       hold_i;
  logic       wr_en_o;
  logic [2:0] wr_reg_o;
  logic [7:0] wr_data_o;
  logic [2:0] q_reg1_i;
  logic [2:0] q_reg2_i;
  logic       byp_hit1_o;
  logic [7:0] byp_data1_o;
  logic       byp_hit2_o;
  logic [7:0] byp_data2_o;
  logic [3:0] count_o;
  logic       busy_o;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [10:0] sb_q[$];
  logic [7:0]  last_wr [8];

  regfile_writeback #(.DATA_W(8), .ADDR_W(3), .DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_reg_i(in_reg_i), .in_data_i(in_data_i), .hold_i(hold_i),
    .wr_en_o(wr_en_o), .wr_reg_o(wr_reg_o), .wr_data_o(wr_data_o),
    .q_reg1_i(q_reg1_i), .q_reg2_i(q_reg2_i),
    .byp_hit1_o(byp_hit1_o), .byp_data1_o(byp_data1_o),
    .byp_hit2_o(byp_hit2_o), .byp_data2_o(byp_data2_o),
    .count_o(count_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Every cycle with wr_en high is one committed write; it must match the oldest expectation.
  always @(negedge clk_i) begin
    if (wr_en_o === 1'b1) begin
      logic [10:0] exp_w;
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL write_unexpected: got r%0d=%02h, required no write", wr_reg_o, wr_data_o);
      end else begin
        exp_w = sb_q.pop_front();
        if ({wr_reg_o, wr_data_o} !== exp_w) begin
          n_fail++;
          $display("FAIL write_order: got r%0d=%02h, required r%0d=%02h",
                   wr_reg_o, wr_data_o, exp_w[10:8], exp_w[7:0]);
        end else begin
          $display("write r%0d=%02h ok", wr_reg_o, wr_data_o);
        end
        last_wr[wr_reg_o] = wr_data_o;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Offers one result; returns one time unit after the accepting edge.
  task automatic push_entry(input logic [2:0] r, input logic [7:0] d, input bit expect_write);
    bit ok = 1'b0;
    in_valid_i = 1'b1;
    in_reg_i   = r;
    in_data_i  = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk_i);
      if (in_ready_o === 1'b1) ok = 1'b1;
      else tick();
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL push_timeout: got in_ready=%b, required 1", in_ready_o);
    end else begin
      if (expect_write) sb_q.push_back({r, d});
      tick();
    end
    in_valid_i = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50 && busy_o !== 1'b0; i++) tick();
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain: got busy=%b count=%0d, required busy=0", name, busy_o, count_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    #1 rst_i = 1'b1;
    #12 rst_i = 1'b0;
    tick();
    n_cmp++;
    if ({count_o, wr_en_o, wr_reg_o, wr_data_o, in_ready_o, busy_o, byp_hit1_o, byp_hit2_o}
        !== {4'd0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got count=%0d wr_en=%b wr_reg=%0d wr_data=%02h ready=%b busy=%b hit=%b%b, required 0 0 0 00 1 0 00",
               count_o, wr_en_o, wr_reg_o, wr_data_o, in_ready_o, busy_o, byp_hit1_o, byp_hit2_o);
    end
    $display("reset state checked");
  endtask

  task automatic test_latency();
    push_entry(3'd3, 8'h5A, 1'b1);
    n_cmp++;
    if ({wr_en_o, count_o} !== {1'b0, 4'd1}) begin
      n_fail++;
      $display("FAIL latency_e0: got wr_en=%b count=%0d, required wr_en=0 count=1", wr_en_o, count_o);
    end
    tick();
    n_cmp++;
    if ({wr_en_o, wr_reg_o, wr_data_o} !== {1'b1, 3'd3, 8'h5A}) begin
      n_fail++;
      $display("FAIL latency_e1: got wr_en=%b r%0d=%02h, required wr_en=1 r3=5a", wr_en_o, wr_reg_o, wr_data_o);
    end
    tick();
    n_cmp++;
    if (wr_en_o !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_e2: got wr_en=%b, required 0", wr_en_o);
    end
  endtask

  task automatic test_hold_full();
    logic [7:0] d;
    hold_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      d = 8'(i * 'h11);
      push_entry(3'(i), d, 1'b1);
      n_cmp++;
      if ({count_o, wr_en_o} !== {4'(i), 1'b0}) begin
        n_fail++;
        $display("FAIL hold_fill: got count=%0d wr_en=%b, required count=%0d wr_en=0", count_o, wr_en_o, i);
      end
    end
    n_cmp++;
    if (in_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready: got in_ready=%b, required 0", in_ready_o);
    end
    in_valid_i = 1'b1;
    in_reg_i   = 3'd5;
    in_data_i  = 8'h55;
    tick();
    tick();
    in_valid_i = 1'b0;
    n_cmp++;
    if ({count_o, in_ready_o} !== {4'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL full_refuse: got count=%0d in_ready=%b, required count=4 in_ready=0", count_o, in_ready_o);
    end
    hold_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (wr_en_o !== 1'b1) begin
        n_fail++;
        $display("FAIL release_burst: got wr_en=%b at drain cycle %0d, required 1", wr_en_o, i);
      end
    end
    tick();
    n_cmp++;
    if ({wr_en_o, busy_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL release_idle: got wr_en=%b busy=%b, required 0 0", wr_en_o, busy_o);
    end
  endtask

  task automatic test_bypass_same_reg();
    logic [7:0] exp_d [3] = '{8'h20, 8'h20, 8'h00};
    logic       exp_h [3] = '{1'b1, 1'b1, 1'b0};
    hold_i   = 1'b1;
    q_reg1_i = 3'd2;
    q_reg2_i = 3'd2;
    push_entry(3'd2, 8'h10, 1'b1);
    push_entry(3'd2, 8'h20, 1'b1);
    n_cmp++;
    if ({byp_hit1_o, byp_data1_o, byp_hit2_o, byp_data2_o} !== {1'b1, 8'h20, 1'b1, 8'h20}) begin
      n_fail++;
      $display("FAIL bypass_youngest: got hit1=%b d1=%02h hit2=%b d2=%02h, required 1 20 1 20",
               byp_hit1_o, byp_data1_o, byp_hit2_o, byp_data2_o);
    end
    hold_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({byp_hit1_o, byp_data1_o} !== {exp_h[i], exp_d[i]}) begin
        n_fail++;
        $display("FAIL bypass_drain: step %0d got hit1=%b d1=%02h, required %b %02h",
                 i, byp_hit1_o, byp_data1_o, exp_h[i], exp_d[i]);
      end
    end
    n_cmp++;
    if (last_wr[2] !== 8'h20) begin
      n_fail++;
      $display("FAIL last_wins: got r2=%02h, required 20", last_wr[2]);
    end
  endtask

  task automatic test_back_to_back();
    hold_i = 1'b1;
    push_entry(3'd0, 8'hA0, 1'b1);
    push_entry(3'd1, 8'hA1, 1'b1);
    hold_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push_entry(3'(i), 8'(8'h80 + i), 1'b1);
      n_cmp++;
      if ({count_o, wr_en_o} !== {4'd2, 1'b1}) begin
        n_fail++;
        $display("FAIL steady_count: cycle %0d got count=%0d wr_en=%b, required count=2 wr_en=1",
                 i, count_o, wr_en_o);
      end
    end
    drain("steady");
  endtask

  task automatic test_async_reset();
    hold_i   = 1'b1;
    q_reg1_i = 3'd4;
    for (int i = 0; i < 4; i++) push_entry(3'(i + 4), 8'(8'hC0 + i), 1'b0);
    hold_i = 1'b0;
    tick();
    #2 rst_i = 1'b1;
    #1;
    n_cmp++;
    if ({wr_en_o, count_o, in_ready_o, busy_o, byp_hit1_o} !== {1'b0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got wr_en=%b count=%0d ready=%b busy=%b hit1=%b, required 0 0 1 0 0",
               wr_en_o, count_o, in_ready_o, busy_o, byp_hit1_o);
    end
    #13 rst_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if (wr_en_o !== 1'b0) begin
        n_fail++;
        $display("FAIL discarded_write: got wr_en=%b r%0d=%02h, required no write", wr_en_o, wr_reg_o, wr_data_o);
      end
    end
  endtask

  task automatic test_bypass_miss();
    hold_i   = 1'b1;
    q_reg1_i = 3'd6;
    q_reg2_i = 3'd7;
    push_entry(3'd1, 8'h11, 1'b1);
    push_entry(3'd6, 8'h66, 1'b1);
    n_cmp++;
    if ({byp_hit2_o, byp_data2_o, byp_hit1_o, byp_data1_o} !== {1'b0, 8'h00, 1'b1, 8'h66}) begin
      n_fail++;
      $display("FAIL bypass_miss: got hit2=%b d2=%02h hit1=%b d1=%02h, required 0 00 1 66",
               byp_hit2_o, byp_data2_o, byp_hit1_o, byp_data1_o);
    end
    hold_i = 1'b0;
    drain("miss");
  endtask

  initial begin
    in_valid_i = 1'b0;
    in_reg_i   = '0;
    in_data_i  = '0;
    hold_i     = 1'b0;
    q_reg1_i   = '0;
    q_reg2_i   = '0;
    foreach (last_wr[i]) last_wr[i] = '0;
    test_reset();
    test_latency();
    test_hold_full();
    test_bypass_same_reg();
    test_back_to_back();
    test_async_reset();
    test_bypass_miss();
    tick();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_writes: got %0d outstanding, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
